lift_call_queue: RTL and testbench

Upstream request stage for the lift controller. Latches hall calls and car-button presses into a per-floor pending bitmap and selects the next target floor with a SCAN (elevator-sweep) policy. Presents one target at a time to the controller, and clears a request when the car reports arrival at that floor.

---
 rtl/lift_call_queue.sv | 171 +++++++++++++++++
 tb/tb_lift_call_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_queue.sv
// Purpose : latch hall/car calls into a per-floor pending bitmap and hand one SCAN-ordered target at a time to the lift controller.
// Latency : a call sampled at edge N is pending after N, dispatched after N+1, and presented as a valid target after N+2.
// Backpr. : i_busy holds the queue in IDLE, so no dispatch starts; calls keep accumulating in the bitmap meanwhile.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_hall_call_f           landing call floor code (0 = none)
//   i_car_call_f            in-car button floor code (0 = none)
//   i_elev_f                current car floor reported by the controller
//   i_busy                  controller busy, blocks new dispatches
//   i_arrived               one-cycle pulse: car stopped at i_elev_f with doors open
//   o_target_f/o_target_vld floor requested from the controller, held stable while valid
//   o_pending               pending bitmap, bit k = floor k+1
//   o_dir                   sweep direction (1 = up)
module lift_call_queue #(
    parameter int NUM_FLOORS = 7,
    parameter int FW         = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FW-1:0]         i_hall_call_f,
    input  logic [FW-1:0]         i_car_call_f,
    input  logic [FW-1:0]         i_elev_f,
    input  logic                  i_busy,
    input  logic                  i_arrived,
    output logic [FW-1:0]         o_target_f,
    output logic                  o_target_vld,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_dir
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_SERVE    = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FW-1:0]         r_target_f;
    logic                  r_target_vld;
    logic                  r_dir;

    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_avail;
    logic [FW-1:0]         w_up_ge;
    logic [FW-1:0]         w_up_gt;
    logic [FW-1:0]         w_dn_le;
    logic [FW-1:0]         w_dn_lt;
    logic [FW-1:0]         w_sel;
    logic                  w_sel_dir;
    state_t                w_state_nxt;
    logic [FW-1:0]         w_tgt_nxt;
    logic                  w_vld_nxt;
    logic                  w_dir_nxt;

    // Floor codes outside 1..NUM_FLOORS match no bit and are dropped here.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            w_set[k] = (i_hall_call_f == FW'(k + 1)) || (i_car_call_f == FW'(k + 1));
            w_clr[k] = i_arrived && (i_elev_f == FW'(k + 1));
        end
    end

    // A floor being cleared this cycle is no longer a candidate for dispatch.
    assign w_avail = r_pending & ~w_clr;

    // Nearest candidates on either side of the car. Ascending-floor searches
    // scan top-down so the last hit is the lowest; descending ones scan bottom-up.
    always_comb begin
        w_up_ge = '0;
        w_up_gt = '0;
        w_dn_le = '0;
        w_dn_lt = '0;
        for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
            if (w_avail[k] && (FW'(k + 1) >= i_elev_f)) w_up_ge = FW'(k + 1);
            if (w_avail[k] && (FW'(k + 1) >  i_elev_f)) w_up_gt = FW'(k + 1);
        end
        for (int k = 0; k < NUM_FLOORS; k++) begin
            if (w_avail[k] && (FW'(k + 1) <= i_elev_f)) w_dn_le = FW'(k + 1);
            if (w_avail[k] && (FW'(k + 1) <  i_elev_f)) w_dn_lt = FW'(k + 1);
        end
    end

    // SCAN: keep sweeping while anything lies ahead (including the current
    // floor), otherwise reverse. A target at the car's floor keeps r_dir.
    always_comb begin
        w_sel     = '0;
        w_sel_dir = r_dir;
        if (r_dir) begin
            if (w_up_ge != '0) begin
                w_sel = w_up_ge;
            end else begin
                w_sel     = w_dn_lt;
                w_sel_dir = 1'b0;
            end
        end else begin
            if (w_dn_le != '0) begin
                w_sel = w_dn_le;
            end else begin
                w_sel     = w_up_gt;
                w_sel_dir = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_target_f;
        w_vld_nxt   = r_target_vld;
        w_dir_nxt   = r_dir;
        case (r_state)
            S_IDLE: begin
                w_tgt_nxt = '0;
                w_vld_nxt = 1'b0;
                if ((r_pending != '0) && !i_busy) w_state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (w_avail != '0) begin
                    w_tgt_nxt   = w_sel;
                    w_vld_nxt   = 1'b1;
                    w_dir_nxt   = w_sel_dir;
                    w_state_nxt = S_SERVE;
                end else begin
                    w_tgt_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVE: begin
                // Arrivals elsewhere only drop that floor's bit; the target is fixed.
                if (i_arrived && (i_elev_f == r_target_f)) begin
                    w_tgt_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tgt_nxt   = '0;
                w_vld_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_target_f   <= '0;
            r_target_vld <= 1'b0;
            r_dir        <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            // Clear is applied after set so a same-cycle collision ends cleared.
            r_pending    <= (r_pending | w_set) & ~w_clr;
            r_target_f   <= w_tgt_nxt;
            r_target_vld <= w_vld_nxt;
            r_dir        <= w_dir_nxt;
        end
    end

    assign o_target_f   = r_target_f;
    assign o_target_vld = r_target_vld;
    assign o_pending    = r_pending;
    assign o_dir        = r_dir;

endmodule

// File: tb/tb_lift_call_queue.sv
// Purpose : exercise lift_call_queue with directed scenarios, then random traffic against a floor-level model.
// Latency : model advances once per clock edge; outputs are checked 1 time unit after the edge.
// Backpr. : i_busy is driven directly, both held for long stretches and randomised.
module tb_lift_call_queue;

    localparam int N  = 7;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] hall_call_f;
    logic [FW-1:0] car_call_f;
    logic [FW-1:0] elev_f;
    logic          busy;
    logic          arrived;
    logic [FW-1:0] target_f;
    logic          target_vld;
    logic [N-1:0]  pending;
    logic          dir;

    int errors = 0;
    int checks = 0;

    // Model state: pending calls indexed by floor number (entry 0 unused).
    bit m_pend [0:N];
    int m_phase;       // 0 waiting, 1 choosing, 2 travelling
    int m_tgt;
    bit m_vld;
    bit m_dir;

    lift_call_queue #(.NUM_FLOORS(N), .FW(FW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_hall_call_f (hall_call_f),
        .i_car_call_f  (car_call_f),
        .i_elev_f      (elev_f),
        .i_busy        (busy),
        .i_arrived     (arrived),
        .o_target_f    (target_f),
        .o_target_vld  (target_vld),
        .o_pending     (pending),
        .o_dir         (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_bitmap();
        logic [N-1:0] b;
        b = '0;
        for (int f = 1; f <= N; f++) b[f-1] = m_pend[f];
        return b;
    endfunction

    // SCAN choice over a set of floors, from the car floor e and direction d.
    task automatic scan_pick(input bit av [0:N], input int e, input bit d, output int t, output bit nd);
        int lo_ge, lo_gt, hi_le, hi_lt;
        lo_ge = 0; lo_gt = 0; hi_le = 0; hi_lt = 0;
        for (int f = 1; f <= N; f++) begin
            if (av[f]) begin
                if (f >= e && lo_ge == 0) lo_ge = f;
                if (f >  e && lo_gt == 0) lo_gt = f;
                if (f <= e) hi_le = f;
                if (f <  e) hi_lt = f;
            end
        end
        nd = d;
        if (d) begin
            t = lo_ge;
            if (t == 0) begin t = hi_lt; nd = 1'b0; end
        end else begin
            t = hi_le;
            if (t == 0) begin t = lo_gt; nd = 1'b1; end
        end
    endtask

    // Advance the model using the inputs present at the coming edge, then
    // let the edge happen and settle.
    task automatic tick();
        bit nxt [0:N];
        bit av  [0:N];
        int e, h, c, t;
        bit any_p, any_av, nd;
        e = int'(elev_f); h = int'(hall_call_f); c = int'(car_call_f);
        any_p = 1'b0; any_av = 1'b0;
        for (int f = 0; f <= N; f++) begin
            av[f]  = m_pend[f] && !(arrived && f == e);
            nxt[f] = (m_pend[f] || (f != 0 && (f == h || f == c))) && !(arrived && f == e);
            if (f != 0 && m_pend[f]) any_p = 1'b1;
            if (f != 0 && av[f]) any_av = 1'b1;
        end
        if (rst) begin
            for (int f = 0; f <= N; f++) nxt[f] = 1'b0;
            m_phase = 0; m_tgt = 0; m_vld = 1'b0; m_dir = 1'b1;
        end else begin
            case (m_phase)
                0: if (any_p && !busy) m_phase = 1;
                1: begin
                    if (any_av) begin
                        scan_pick(av, e, m_dir, t, nd);
                        m_tgt = t; m_dir = nd; m_vld = 1'b1; m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: if (arrived && e == m_tgt) begin
                    m_tgt = 0; m_vld = 1'b0; m_phase = 0;
                end
            endcase
        end
        m_pend = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pend"}, 32'(pending),    32'(model_bitmap()));
        chk({tag, ".tgt"},  32'(target_f),   32'(m_tgt));
        chk({tag, ".vld"},  32'(target_vld), 32'(m_vld));
        chk({tag, ".dir"},  32'(dir),        32'(m_dir));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pend"}, 32'(pending),    32'h0);
        chk({tag, ".tgt"},  32'(target_f),   32'h0);
        chk({tag, ".vld"},  32'(target_vld), 32'h0);
        chk({tag, ".dir"},  32'(dir),        32'h1);
    endtask

    initial begin
        bit vld_seen;
        for (int f = 0; f <= N; f++) m_pend[f] = 1'b0;
        m_phase = 0; m_tgt = 0; m_vld = 1'b0; m_dir = 1'b1;
        rst = 1'b1; busy = 1'b0; arrived = 1'b0;
        hall_call_f = '0; car_call_f = '0; elev_f = 3'd1;
        #1;

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            hall_call_f = FW'($urandom); car_call_f = FW'($urandom);
            elev_f = FW'($urandom); busy = 1'($urandom); arrived = 1'($urandom);
            tick();
        end
        chk_reset_vals("reset");
        rst = 1'b0; busy = 1'b0; arrived = 1'b0;
        hall_call_f = '0; car_call_f = '0;

        // 2. single call
        elev_f = 3'd1; car_call_f = 3'd5;
        tick();
        car_call_f = 3'd0;
        chk("single.pend", 32'(pending), 32'b0010000);
        tick();
        chk("single.vld_dispatch", 32'(target_vld), 32'h0);
        tick();
        chk("single.tgt", 32'(target_f), 32'd5);
        chk("single.vld", 32'(target_vld), 32'h1);
        elev_f = 3'd5; arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk("single.arr_pend", 32'(pending), 32'h0);
        chk("single.arr_vld", 32'(target_vld), 32'h0);
        chk("single.arr_tgt", 32'(target_f), 32'h0);

        // 3. SCAN order
        elev_f = 3'd3;
        chk("scan.dir0", 32'(dir), 32'h1);
        hall_call_f = 3'd2; car_call_f = 3'd6;
        tick();
        hall_call_f = 3'd0; car_call_f = 3'd0;
        chk("scan.pend", 32'(pending), 32'b0100010);
        tick(); tick();
        chk("scan.tgt_up", 32'(target_f), 32'd6);
        chk("scan.dir_up", 32'(dir), 32'h1);
        elev_f = 3'd6; arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk("scan.vld_after_arr", 32'(target_vld), 32'h0);
        tick(); tick();
        chk("scan.tgt_down", 32'(target_f), 32'd2);
        chk("scan.dir_down", 32'(dir), 32'h0);
        elev_f = 3'd2; arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk("scan.pend_empty", 32'(pending), 32'h0);

        // 4. busy gating
        busy = 1'b1; hall_call_f = 3'd4;
        tick();
        hall_call_f = 3'd0;
        vld_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (target_vld !== 1'b0) vld_seen = 1'b1;
        end
        chk("busy.held", 32'(vld_seen), 32'h0);
        busy = 1'b0;
        tick(); tick();
        chk("busy.tgt", 32'(target_f), 32'd4);
        chk("busy.vld", 32'(target_vld), 32'h1);
        chk("busy.dir", 32'(dir), 32'h1);
        elev_f = 3'd4; arrived = 1'b1;
        tick();
        arrived = 1'b0;

        // 5. set/clear collision while serving floor 6
        car_call_f = 3'd6;
        tick();
        car_call_f = 3'd0;
        tick(); tick();
        chk("coll.tgt_pre", 32'(target_f), 32'd6);
        elev_f = 3'd3; arrived = 1'b1; hall_call_f = 3'd3;
        tick();
        arrived = 1'b0; hall_call_f = 3'd0;
        chk("coll.pend", 32'(pending), 32'b0100000);
        chk("coll.tgt", 32'(target_f), 32'd6);
        chk("coll.vld", 32'(target_vld), 32'h1);
        tick();
        chk("coll.zero_code", 32'(pending), 32'b0100000);

        // 6. reset mid-serve
        hall_call_f = 3'd2; car_call_f = 3'd3;
        tick();
        hall_call_f = 3'd0; car_call_f = 3'd0;
        chk("rst6.pend_pre", 32'(pending), 32'b0100110);
        chk("rst6.tgt_pre", 32'(target_f), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst6");
        hall_call_f = 3'd2;
        tick();
        hall_call_f = 3'd0;
        tick(); tick();
        chk("rst6.tgt_after", 32'(target_f), 32'd2);
        chk("rst6.vld_after", 32'(target_vld), 32'h1);
        chk("rst6.dir_after", 32'(dir), 32'h0);
        chk_model("dir_model");

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            hall_call_f = ($urandom_range(0, 2) == 0) ? FW'($urandom) : '0;
            car_call_f  = ($urandom_range(0, 2) == 0) ? FW'($urandom) : '0;
            busy        = ($urandom_range(0, 3) == 0);
            arrived     = ($urandom_range(0, 3) == 0);
            if (m_vld && $urandom_range(0, 1) == 1) elev_f = FW'(m_tgt);
            else elev_f = FW'($urandom_range(0, N));
            tick();
            chk_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
